ext_op_sequencer: RTL and testbench

Parametrised sequencer for multi-cycle execution units. It generalises the fixed mul/div valid/ready pairing to NUM_UNITS channels and adds a watchdog timeout, abort and error reporting. It sits between the main FSM and units such as the multiplier, divider and future FPU. It accepts one request at a time, drives the selected unit's valid until that unit's ready, captures the result, and returns a single-cycle response.

---
 rtl/ext_op_sequencer_pkg.sv | 22 ++
 rtl/ext_op_watchdog.sv | 43 ++++
 rtl/ext_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ext_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_op_sequencer_pkg.sv
// Shared types and helpers for the multi-cycle execution-unit sequencer.
package ext_op_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } seq_state_e;

  localparam int unsigned UNIT_MUL = 0;
  localparam int unsigned UNIT_DIV = 1;

  function automatic int unsigned sel_width(input int unsigned num_units);
    return (num_units <= 1) ? 1 : $clog2(num_units);
  endfunction

  // Wide enough to hold the limit itself, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ext_op_watchdog.sv
// Watchdog counter: cleared on issue, counts stalled cycles, flags expiry at LIMIT-1.
module ext_op_watchdog
  import ext_op_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT     = 64,
  parameter int unsigned CNT_WIDTH = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  generate
    if (LIMIT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = (cnt_q == CNT_WIDTH'(LIMIT - 1));
    end
  endgenerate

  // Holding at expiry keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (LIMIT != 0) && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ext_op_sequencer.sv
// Single-outstanding request sequencer for multi-cycle execution units with
// watchdog, abort and error reporting.
module ext_op_sequencer
  import ext_op_sequencer_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OP_WIDTH       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned SEL_WIDTH      = sel_width(NUM_UNITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [SEL_WIDTH-1:0]            req_unit,
  input  logic [OP_WIDTH-1:0]             req_op,
  input  logic [DATA_WIDTH-1:0]           req_a,
  input  logic [DATA_WIDTH-1:0]           req_b,
  input  logic                            kill,
  output logic [NUM_UNITS-1:0]            unit_valid,
  output logic [OP_WIDTH-1:0]             unit_op,
  output logic [DATA_WIDTH-1:0]           unit_a,
  output logic [DATA_WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]            unit_ready,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_result,
  output logic                            rsp_error,
  output logic                            rsp_timeout,
  output logic                            busy
);

  seq_state_e            state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;

  logic                  req_unit_ok;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_result;
  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expired;

  assign req_unit_ok = (32'(req_unit) < NUM_UNITS);

  // Only the selected unit's ready/result are visible to the FSM.
  always_comb begin
    sel_ready  = 1'b0;
    sel_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        sel_ready  = unit_ready[i];
        sel_result = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  ext_op_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          tmo_d = 1'b0;
          if (req_unit_ok) begin
            state_d  = StIssue;
            sel_d    = req_unit;
            op_d     = req_op;
            a_d      = req_a;
            b_d      = req_b;
            err_d    = 1'b0;
            wd_clear = 1'b1;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end
      StIssue: begin
        // Abort beats completion, and completion beats expiry.
        if (kill) begin
          state_d = StIdle;
        end else if (sel_ready) begin
          state_d  = StResp;
          result_d = sel_result;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
        end else if (wd_expired) begin
          state_d = StResp;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          wd_enable = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    unit_valid = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_valid[i] = (state_q == StIssue) && (sel_q == SEL_WIDTH'(i));
    end
  end

  assign unit_op     = op_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign req_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_result  = result_q;
  assign rsp_error   = rsp_valid & err_q;
  assign rsp_timeout = rsp_valid & tmo_q;

endmodule

// File: tb/tb_ext_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_ext_op_sequencer;
  import ext_op_sequencer_pkg::*;

  localparam int unsigned NU = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;
  localparam int unsigned TO = 8;
  localparam int unsigned SW = 2;
  localparam int NEVER = 1000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid, req_ready;
  logic [SW-1:0]    req_unit;
  logic [OW-1:0]    req_op;
  logic [DW-1:0]    req_a, req_b;
  logic             kill;
  logic [NU-1:0]    unit_valid;
  logic [OW-1:0]    unit_op;
  logic [DW-1:0]    unit_a, unit_b;
  logic [NU-1:0]    unit_ready;
  logic [NU*DW-1:0] unit_result;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_result;
  logic             rsp_error, rsp_timeout, busy;

  ext_op_sequencer #(
    .NUM_UNITS      (NU),
    .DATA_WIDTH     (DW),
    .OP_WIDTH       (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_unit    (req_unit),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .kill        (kill),
    .unit_valid  (unit_valid),
    .unit_op     (unit_op),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_ready  (unit_ready),
    .unit_result (unit_result),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit models: unit 0 = a*b+op, unit 1 = programmable constant, unit 2 = a^b.
  int            dly [NU];
  int            vcnt[NU];
  logic [NU-1:0] noise;
  logic [DW-1:0] res1;

  assign unit_result = {unit_a ^ unit_b, res1, unit_a * unit_b + DW'(unit_op)};

  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) vcnt[i] <= unit_valid[i] ? vcnt[i] + 1 : 0;
  end

  always_comb begin
    unit_ready = '0;
    for (int i = 0; i < NU; i++) begin
      unit_ready[i] = (unit_valid[i] && (vcnt[i] == dly[i])) | noise[i];
    end
  end

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    logic          tmo;
    int            cyc;
    logic [NU-1:0] mask;
    int            vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks unit_valid activity per transaction and checks each response.
  int            vcyc = 0;
  logic [NU-1:0] vmask = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        vcyc  = 0;
        vmask = '0;
      end
      if (unit_valid != '0) begin
        vcyc++;
        vmask |= unit_valid;
      end
      if (rsp_valid) begin
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(mon_e.res));
          chk("rsp_error", 64'(rsp_error), 64'(mon_e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
          chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("unit_valid_cycles", 64'(vcyc), 64'(mon_e.vcyc));
          chk("unit_valid_mask", 64'(vmask), 64'(mon_e.mask));
        end
      end else begin
        chk("rsp_flags_idle", 64'({rsp_error, rsp_timeout}), 64'd0);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] unit, input logic [OW-1:0] op,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, output int acc);
    chk("req_ready_before_send", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_unit  = unit;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [DW-1:0] res, input logic err, input logic tmo,
                            input int at, input logic [NU-1:0] mask, input int vc);
    exp_t e;
    e.res  = res;
    e.err  = err;
    e.tmo  = tmo;
    e.cyc  = at;
    e.mask = mask;
    e.vcyc = vc;
    sb.push_back(e);
  endtask

  task automatic check_aborted(input string tag);
    chk({tag, "_unit_valid"}, 64'(unit_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int acc;
    req_valid = 1'b0;
    req_unit  = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    kill      = 1'b0;
    noise     = '0;
    res1      = '0;
    for (int i = 0; i < NU; i++) dly[i] = NEVER;

    wait_cycles(3);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_unit_valid", 64'(unit_valid), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    reset = 1'b0;
    wait_cycles(1);

    // Unit 0 ready in its 4th valid cycle: 7*6+0 = 42.
    dly[UNIT_MUL] = 3;
    send(SW'(UNIT_MUL), 3'd0, 32'd7, 32'd6, acc);
    expect_rsp(32'd42, 1'b0, 1'b0, acc + 4, 3'b001, 4);
    wait_cycles(8);

    // Unit 1 ready in first ISSUE cycle, unit 0 ready noise ignored.
    dly[UNIT_DIV]   = 0;
    res1            = 32'hDEAD_BEEF;
    noise[UNIT_MUL] = 1'b1;
    send(SW'(UNIT_DIV), 3'd1, 32'd1, 32'd2, acc);
    expect_rsp(32'hDEAD_BEEF, 1'b0, 1'b0, acc + 1, 3'b010, 1);
    wait_cycles(5);
    noise = '0;

    // Out-of-range unit: immediate error, result held.
    send(2'd3, 3'd0, 32'd9, 32'd9, acc);
    expect_rsp(32'hDEAD_BEEF, 1'b1, 1'b0, acc, 3'b000, 0);
    wait_cycles(5);

    // Unit 1 never ready: watchdog after 8 valid cycles.
    dly[UNIT_DIV] = NEVER;
    send(SW'(UNIT_DIV), 3'd0, 32'd3, 32'd4, acc);
    expect_rsp(32'hDEAD_BEEF, 1'b1, 1'b1, acc + 8, 3'b010, 8);
    wait_cycles(13);

    // Ready on the expiry cycle wins: 0x1234*1+0.
    dly[UNIT_MUL] = 7;
    send(SW'(UNIT_MUL), 3'd0, 32'h1234, 32'd1, acc);
    expect_rsp(32'h1234, 1'b0, 1'b0, acc + 8, 3'b001, 8);
    wait_cycles(13);

    // Kill in the 2nd ISSUE cycle, unit stalled.
    send(SW'(UNIT_DIV), 3'd0, 32'd1, 32'd1, acc);
    wait_cycles(1);
    kill = 1'b1;
    wait_cycles(1);
    kill = 1'b0;
    check_aborted("kill");
    wait_cycles(4);

    // Kill together with ready: 5*5 must be discarded.
    dly[UNIT_MUL] = 1;
    send(SW'(UNIT_MUL), 3'd0, 32'd5, 32'd5, acc);
    wait_cycles(1);
    kill = 1'b1;
    wait_cycles(1);
    kill = 1'b0;
    check_aborted("kill_ready");
    wait_cycles(4);

    send(2'd3, 3'd0, 32'd0, 32'd0, acc);
    expect_rsp(32'h1234, 1'b1, 1'b0, acc, 3'b000, 0);
    wait_cycles(5);

    // Normal service after aborts: 0x11*7+2 = 0x79.
    send(SW'(UNIT_MUL), 3'd2, 32'h11, 32'd7, acc);
    expect_rsp(32'h79, 1'b0, 1'b0, acc + 2, 3'b001, 2);
    wait_cycles(6);

    // Reset mid-ISSUE overrides kill and a pending request.
    send(SW'(UNIT_DIV), 3'd5, 32'hAAAA, 32'h5555, acc);
    wait_cycles(1);
    reset     = 1'b1;
    kill      = 1'b1;
    req_valid = 1'b1;
    wait_cycles(1);
    chk("midreset_unit_valid", 64'(unit_valid), 64'd0);
    chk("midreset_unit_op", 64'(unit_op), 64'd0);
    chk("midreset_unit_a", 64'(unit_a), 64'd0);
    chk("midreset_unit_b", 64'(unit_b), 64'd0);
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_rsp_result", 64'(rsp_result), 64'd0);
    chk("midreset_rsp_error", 64'(rsp_error), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd1);
    chk("midreset_busy", 64'(busy), 64'd0);
    reset     = 1'b0;
    kill      = 1'b0;
    req_valid = 1'b0;
    wait_cycles(2);

    // Result register was cleared by reset.
    send(2'd3, 3'd0, 32'd0, 32'd0, acc);
    expect_rsp(32'd0, 1'b1, 1'b0, acc, 3'b000, 0);
    wait_cycles(6);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
